// File: rtl/cpu_cu.sv
// cpu_cu: fetch/decode/execute control unit for the CPU.
// Drives the execution unit's PC, IR, address-mux, register-file, S-mux and ALU controls,
// plus the RAM write strobe. Every instruction takes FETCH, DECODE and one EXEC cycle.
// Strobes are registered (computed from the next state) and forced low while reset is high.
// Register addresses and Alu_Op are decoded from IR_In in every state.
// Optional feature macro: CPU_CU_SINGLE_STEP_EN adds a `step` input. Each EXEC state then
// parks in STEP_WAIT until a rising edge on `step`.
module cpu_cu (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] IR_In,
  input  logic        carry,
  input  logic        N,
  input  logic        Z,
`ifdef CPU_CU_SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic        pc_inc,
  output logic        pc_ld,
  output logic        pc_sel,
  output logic        adr_sel,
  output logic        ir_ld,
  output logic        S_Sel,
  output logic        W_En,
  output logic        mem_we,
  output logic [3:0]  Alu_Op,
  output logic [2:0]  W_Adr,
  output logic [2:0]  R_Adr,
  output logic [2:0]  S_Adr,
  output logic [3:0]  state,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [3:0] {
    StFetch    = 4'h0,
    StDecode   = 4'h1,
    StExecAlu  = 4'h2,
    StExecLd   = 4'h3,
    StExecSt   = 4'h4,
    StExecBr   = 4'h5,
    StExecJr   = 4'h6,
    StHalt     = 4'h7,
    StStepWait = 4'h8
  } state_e;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLd  = 4'h1;
  localparam logic [3:0] OpSt  = 4'h2;
  localparam logic [3:0] OpBr  = 4'h3;
  localparam logic [3:0] OpJr  = 4'h4;
  localparam logic [3:0] OpHlt = 4'h7;

  state_e     state_q, state_d;
  logic [2:0] flags_q;  // {Cf, Nf, Zf}
  logic       illegal_q, illegal_d;

  logic pc_inc_q, pc_ld_q, pc_sel_q, adr_sel_q, ir_ld_q, s_sel_q, w_en_q, mem_we_q;
  logic pc_inc_d, pc_ld_d, pc_sel_d, adr_sel_d, ir_ld_d, s_sel_d, w_en_d, mem_we_d;

  logic [3:0] op;
  logic [3:0] cond;
  logic       is_alu;
  logic       cond_ok;
  logic       step_go;
  state_e     exec_next;

  assign op     = IR_In[15:12];
  assign cond   = IR_In[11:8];
  assign is_alu = IR_In[15];

  // Offset bits are consumed by the EU's PC adder; the low bits have no use here.
  logic unused_ir;
  assign unused_ir = ^IR_In[2:0];

`ifdef CPU_CU_SINGLE_STEP_EN
  logic step_q;
  assign step_go   = step & ~step_q;
  assign exec_next = StStepWait;
`else
  assign step_go   = 1'b1;
  assign exec_next = StFetch;
`endif

  // Branch condition evaluated against the latched flags only, never the live ALU flags.
  function automatic logic cond_holds(input logic [3:0] c, input logic [2:0] f);
    logic r;
    case (c)
      4'h0:    r = 1'b1;
      4'h1:    r = f[0];
      4'h2:    r = ~f[0];
      4'h3:    r = f[1];
      4'h4:    r = ~f[1];
      4'h5:    r = f[2];
      4'h6:    r = ~f[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign cond_ok = cond_holds(cond, flags_q);

  // Next-state and sticky illegal-opcode decode.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        if (is_alu) begin
          state_d = StExecAlu;
        end else begin
          unique case (op)
            OpNop:   state_d = StExecBr;  // NOP reuses the branch slot with pc_ld held low
            OpLd:    state_d = StExecLd;
            OpSt:    state_d = StExecSt;
            OpBr:    state_d = StExecBr;
            OpJr:    state_d = StExecJr;
            OpHlt:   state_d = StHalt;
            default: begin
              state_d   = StHalt;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      StExecAlu, StExecLd, StExecSt, StExecBr, StExecJr: state_d = exec_next;
      StHalt:     state_d = StHalt;
      StStepWait: state_d = step_go ? StFetch : StStepWait;
      default:    state_d = StFetch;
    endcase
  end

  // Strobe values for the state being entered, so the registered outputs line up with it.
  always_comb begin
    pc_inc_d  = (state_d == StFetch);
    ir_ld_d   = (state_d == StFetch);
    adr_sel_d = (state_d == StExecLd) || (state_d == StExecSt);
    s_sel_d   = (state_d == StExecLd);
    w_en_d    = (state_d == StExecAlu) || (state_d == StExecLd);
    mem_we_d  = (state_d == StExecSt);
    pc_sel_d  = (state_d == StExecJr);
    pc_ld_d   = (state_d == StExecJr) ||
                ((state_d == StExecBr) && !is_alu && (op == OpBr) && cond_ok);
  end

  // State, flags, sticky illegal and registered strobes; reset parks the FSM in FETCH.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StFetch;
      flags_q   <= 3'b000;
      illegal_q <= 1'b0;
      pc_inc_q  <= 1'b1;
      ir_ld_q   <= 1'b1;
      adr_sel_q <= 1'b0;
      s_sel_q   <= 1'b0;
      w_en_q    <= 1'b0;
      mem_we_q  <= 1'b0;
      pc_sel_q  <= 1'b0;
      pc_ld_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (state_q == StExecAlu) begin
        flags_q <= {carry, N, Z};
      end
      pc_inc_q  <= pc_inc_d;
      ir_ld_q   <= ir_ld_d;
      adr_sel_q <= adr_sel_d;
      s_sel_q   <= s_sel_d;
      w_en_q    <= w_en_d;
      mem_we_q  <= mem_we_d;
      pc_sel_q  <= pc_sel_d;
      pc_ld_q   <= pc_ld_d;
    end
  end

`ifdef CPU_CU_SINGLE_STEP_EN
  // Step edge-detector history; cleared by reset so a stale level cannot count as an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end
`endif

  // Write/load strobes are masked by reset so an aborted instruction never commits.
  assign pc_inc  = pc_inc_q & ~reset;
  assign pc_ld   = pc_ld_q & ~reset;
  assign ir_ld   = ir_ld_q & ~reset;
  assign W_En    = w_en_q & ~reset;
  assign mem_we  = mem_we_q & ~reset;
  assign pc_sel  = pc_sel_q;
  assign adr_sel = adr_sel_q;
  assign S_Sel   = s_sel_q;

  // Datapath selects follow IR_In continuously so the EU settles before EXEC.
  assign Alu_Op = is_alu ? {1'b0, IR_In[14:12]} : 4'h0;
  assign W_Adr  = IR_In[11:9];
  assign R_Adr  = IR_In[8:6];
  assign S_Adr  = (!is_alu && (op == OpJr)) ? IR_In[8:6] : IR_In[5:3];

  assign state   = state_q;
  assign halted  = (state_q == StHalt);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_cpu_cu.sv
// Directed bench for cpu_cu: drives instruction words and ALU flags by hand and checks
// the control strobes, decoded addresses and FSM state against hand-computed values.
module tb_cpu_cu;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] IR_In;
  logic        carry, N, Z;
  logic        pc_inc, pc_ld, pc_sel, adr_sel, ir_ld, S_Sel, W_En, mem_we;
  logic [3:0]  Alu_Op;
  logic [2:0]  W_Adr, R_Adr, S_Adr;
  logic [3:0]  state;
  logic        halted, illegal;
`ifdef CPU_CU_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  cpu_cu dut (
    .clock   (clock),
    .reset   (reset),
    .IR_In   (IR_In),
    .carry   (carry),
    .N       (N),
    .Z       (Z),
`ifdef CPU_CU_SINGLE_STEP_EN
    .step    (step),
`endif
    .pc_inc  (pc_inc),
    .pc_ld   (pc_ld),
    .pc_sel  (pc_sel),
    .adr_sel (adr_sel),
    .ir_ld   (ir_ld),
    .S_Sel   (S_Sel),
    .W_En    (W_En),
    .mem_we  (mem_we),
    .Alu_Op  (Alu_Op),
    .W_Adr   (W_Adr),
    .R_Adr   (R_Adr),
    .S_Adr   (S_Adr),
    .state   (state),
    .halted  (halted),
    .illegal (illegal)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // From FETCH: present the instruction, pass DECODE, land in the EXEC (or HALT) state.
  task automatic fetch_decode(input logic [15:0] ir);
    chk("fetch_state", {12'h0, state}, 16'h0);
    chk("fetch_ir_ld", {15'h0, ir_ld}, 16'h1);
    chk("fetch_pc_inc", {15'h0, pc_inc}, 16'h1);
    chk("fetch_adr_sel", {15'h0, adr_sel}, 16'h0);
    IR_In = ir;
    tick();
    chk("decode_state", {12'h0, state}, 16'h1);
    chk("decode_quiet", {11'h0, ir_ld, pc_inc, pc_ld, W_En, mem_we}, 16'h0);
    tick();
  endtask

  // Leave an EXEC state and return to FETCH (through STEP_WAIT when stepping is built in).
  task automatic finish_exec();
    tick();
`ifdef CPU_CU_SINGLE_STEP_EN
    chk("step_wait_state", {12'h0, state}, 16'h8);
    chk("step_wait_quiet", {11'h0, ir_ld, pc_inc, pc_ld, W_En, mem_we}, 16'h0);
    step = 1'b1;
    tick();
    step = 1'b0;
`endif
    chk("back_to_fetch", {12'h0, state}, 16'h0);
  endtask

  task automatic br_check(input string tag, input logic [3:0] c, input logic exp_ld);
    fetch_decode({4'h3, c, 8'hFE});
    chk("br_state", {12'h0, state}, 16'h5);
    chk(tag, {15'h0, pc_ld}, {15'h0, exp_ld});
    chk("br_pc_sel", {15'h0, pc_sel}, 16'h0);
    finish_exec();
  endtask

  initial begin
    reset = 1'b1;
    IR_In = 16'h0000;
    {carry, N, Z} = 3'b000;
    #1;
    chk("reset_strobes_low", {11'h0, ir_ld, pc_inc, pc_ld, W_En, mem_we}, 16'h0);
    tick();
    chk("reset_state", {12'h0, state}, 16'h0);
    chk("reset_halted", {15'h0, halted}, 16'h0);
    chk("reset_illegal", {15'h0, illegal}, 16'h0);
    reset = 1'b0;
    #1;

    // ALU add R1 <= R2 + R3.
    fetch_decode(16'h8298);
    chk("alu_addr", {7'h0, W_Adr, R_Adr, S_Adr}, {7'h0, 3'd1, 3'd2, 3'd3});
    chk("alu_op_add", {12'h0, Alu_Op}, 16'h0);
    chk("alu_state", {12'h0, state}, 16'h2);
    chk("alu_w_en", {15'h0, W_En}, 16'h1);
    chk("alu_s_sel", {15'h0, S_Sel}, 16'h0);
    {carry, N, Z} = 3'b000;
    finish_exec();
    chk("after_alu_w_en", {15'h0, W_En}, 16'h0);

    // LD R4, [R2].
    fetch_decode(16'h1880);
    chk("ld_state", {12'h0, state}, 16'h3);
    chk("ld_ctrl", {12'h0, adr_sel, S_Sel, W_En, mem_we}, 16'b1110);
    chk("ld_addr", {10'h0, W_Adr, R_Adr}, {10'h0, 3'd4, 3'd2});
    finish_exec();

    // ST R5 -> [R2]: mem_we for exactly the EXEC cycle.
    fetch_decode(16'h20A8);
    chk("st_state", {12'h0, state}, 16'h4);
    chk("st_ctrl", {12'h0, adr_sel, S_Sel, W_En, mem_we}, 16'b1001);
    chk("st_alu_op", {12'h0, Alu_Op}, 16'h0);
    chk("st_s_adr", {13'h0, S_Adr}, 16'd5);
    finish_exec();
    chk("st_mem_we_once", {15'h0, mem_we}, 16'h0);

    // Subtract giving zero latches Zf=1; live Z then dropped to prove branches use latched flags.
    fetch_decode(16'h9298);
    chk("sub_alu_op", {12'h0, Alu_Op}, 16'h1);
    {carry, N, Z} = 3'b001;
    finish_exec();
    {carry, N, Z} = 3'b000;
    br_check("br_z_taken", 4'h1, 1'b1);
    br_check("br_nz_not_taken", 4'h2, 1'b0);

    // ALU sets C=1 N=1 Z=0; live flags then inverted.
    fetch_decode(16'hB298);
    chk("alu_op3", {12'h0, Alu_Op}, 16'h3);
    {carry, N, Z} = 3'b110;
    finish_exec();
    {carry, N, Z} = 3'b001;
    br_check("br_c_taken", 4'h5, 1'b1);
    br_check("br_nc_not_taken", 4'h6, 1'b0);
    br_check("br_n_taken", 4'h3, 1'b1);
    br_check("br_nn_not_taken", 4'h4, 1'b0);
    br_check("br_z_not_taken", 4'h1, 1'b0);
    br_check("br_always", 4'h0, 1'b1);
    br_check("br_never", 4'h9, 1'b0);

    // LD with live flags toggling must not disturb latched flags.
    fetch_decode(16'h1880);
    {carry, N, Z} = 3'b000;
    finish_exec();
    br_check("flags_kept_after_ld", 4'h5, 1'b1);

    // NOP: no strobes in its EXEC cycle.
    fetch_decode(16'h0000);
    chk("nop_quiet", {10'h0, pc_ld, W_En, mem_we, ir_ld, pc_inc, halted}, 16'h0);
    finish_exec();

    // JR R3.
    IR_In = 16'h40C0;
    #1;
    chk("jr_s_adr", {13'h0, S_Adr}, 16'd3);
    fetch_decode(16'h40C0);
    chk("jr_state", {12'h0, state}, 16'h6);
    chk("jr_ctrl", {12'h0, pc_sel, pc_ld, W_En, mem_we}, 16'b1100);
    chk("jr_alu_op", {12'h0, Alu_Op}, 16'h0);
    finish_exec();
    chk("after_jr_pc_ld", {15'h0, pc_ld}, 16'h0);

    // Undefined opcode 0x5 halts with illegal set.
    fetch_decode(16'h5000);
    chk("ill_state", {12'h0, state}, 16'h7);
    chk("ill_flags", {14'h0, halted, illegal}, 16'b11);
    chk("ill_quiet", {11'h0, ir_ld, pc_inc, pc_ld, W_En, mem_we}, 16'h0);
    tick();
    tick();
    chk("halt_absorbing", {12'h0, state}, 16'h7);
    chk("halt_still_quiet", {11'h0, ir_ld, pc_inc, pc_ld, W_En, mem_we}, 16'h0);
    reset = 1'b1;
    tick();
    chk("ill_reset_state", {12'h0, state}, 16'h0);
    chk("ill_reset_flags", {14'h0, halted, illegal}, 16'b00);
    chk("ill_reset_strobes", {15'h0, pc_inc}, 16'h0);
    reset = 1'b0;
    #1;

    // HLT.
    fetch_decode(16'h7000);
    chk("hlt_flags", {14'h0, halted, illegal}, 16'b10);
    chk("hlt_state", {12'h0, state}, 16'h7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;

    // Reset during EXEC_ST aborts the write.
    fetch_decode(16'h20A8);
    chk("st_abort_pre", {15'h0, mem_we}, 16'h1);
    reset = 1'b1;
    #1;
    chk("st_abort_mem_we", {15'h0, mem_we}, 16'h0);
    chk("st_abort_w_en", {15'h0, W_En}, 16'h0);
    tick();
    chk("st_abort_state", {12'h0, state}, 16'h0);
    reset = 1'b0;
    #1;

`ifdef CPU_CU_SINGLE_STEP_EN
    // Three step pulses, 10 cycles apart, release exactly three instructions.
    begin
      int execs = 0;
      int guard = 0;
      IR_In = 16'h0000;
      while (state !== 4'h8 && guard < 6) begin
        tick();
        guard++;
      end
      chk("step_reach_wait", {12'h0, state}, 16'h8);
      for (int i = 0; i < 35; i++) begin
        step = (i < 30) && ((i % 10) == 2 || (i % 10) == 3);
        tick();
        if (state >= 4'h2 && state <= 4'h6) execs++;
      end
      step = 1'b0;
      chk("step_exec_count", execs[15:0], 16'd3);
      chk("step_final_wait", {12'h0, state}, 16'h8);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
